neuron_mac_sequencer: RTL and testbench

//  Sequences one shared add datapath across N binary inputs of a single perceptron neuron:
//  sum = bias + sum(x[i] * w[i]), then step activation. Weights live in a runtime-writable

---
 rtl/neuron_pkg.sv | 25 ++
 rtl/neuron_acc.sv | 30 +++
 rtl/neuron_mac_sequencer.sv | 82 ++++++++
 tb/tb_neuron_mac_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared fixed-point types, FSM states and sign-magnitude conversion helpers
//   Q_M/Q_N/W : default sign-magnitude format Q(Q_M).(Q_N), W = 1+Q_M+Q_N
//   MAXW      : working width of the conversion helpers (any W + guard bits must fit)
package neuron_pkg;
    localparam int Q_M  = 15;
    localparam int Q_N  = 16;
    localparam int W    = 1 + Q_M + Q_N;
    localparam int MAXW = 64;
    typedef logic [W-1:0] fixed_t;
    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;
    // w-bit sign-magnitude (right-aligned in v) to MAXW-bit two's complement; -0 yields 0
    function automatic logic signed [MAXW-1:0] sm_to_tc(input logic [MAXW-1:0] v, input int w);
        logic [MAXW-1:0] mag;
        mag = v & ({MAXW{1'b1}} >> (MAXW - w + 1));
        return |(v & (MAXW'(1) << (w - 1))) ? -$signed(mag) : $signed(mag);
    endfunction
    // MAXW-bit two's complement to w-bit sign-magnitude, magnitude clamped; zero is always +0
    function automatic logic [MAXW-1:0] tc_to_sm_sat(input logic signed [MAXW-1:0] a, input int w);
        logic [MAXW-1:0] mag, lim;
        lim = {MAXW{1'b1}} >> (MAXW - w + 1);
        mag = a[MAXW-1] ? MAXW'(-a) : MAXW'(a);
        mag = (mag > lim) ? lim : mag;
        return a[MAXW-1] ? (mag | (MAXW'(1) << (w - 1))) : mag;
    endfunction
endpackage

// File: rtl/neuron_acc.sv
// neuron_acc: clear/add accumulator over sign-magnitude operands with saturated sign-magnitude view
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i, add_i : clear accumulator (wins), add din_i this edge
//   din_i        : W-bit sign-magnitude operand
//   sum_o, pos_o : saturated sum and (sum > 0) of the value the accumulator takes at this edge
module neuron_acc
    import neuron_pkg::*;
#(
    parameter int W  = neuron_pkg::W,
    parameter int AW = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         add_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] sum_o,
    output logic         pos_o
);
    localparam int WA = W + AW;
    logic signed [WA-1:0] r_acc, w_add, w_nxt;
    // AW guard bits hold N_INPUTS+1 full-scale terms, so the sum never wraps
    assign w_add = WA'(sm_to_tc(MAXW'(din_i), W));
    assign w_nxt = clr_i ? '0 : add_i ? r_acc + w_add : r_acc;
    assign sum_o = W'(tc_to_sm_sat(MAXW'(w_nxt), W));
    assign pos_o = !w_nxt[WA-1] && (w_nxt != '0);
    always_ff @(posedge clk_i) begin
        r_acc <= rst_i ? '0 : w_nxt;
    end
endmodule

// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer: perceptron neuron sequencing one shared adder over N binary inputs plus bias
//   in_valid_i/in_ready_o/x_i     : input pattern handshake
//   cfg_we_i/cfg_addr_i/cfg_data_i: weight writes (addr N_INPUTS = bias), honoured while cfg_ready_o
//   out_valid_o/out_ready_i       : result handshake carrying out_o (step) and sum_o (saturated sum)
module neuron_mac_sequencer
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 2,
    parameter int Q_M      = neuron_pkg::Q_M,
    parameter int Q_N      = neuron_pkg::Q_N
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [N_INPUTS-1:0]                 x_i,
    input  logic                                cfg_we_i,
    input  logic [$clog2(N_INPUTS+1)-1:0]       cfg_addr_i,
    input  logic [Q_M+Q_N:0]                    cfg_data_i,
    output logic                                cfg_ready_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic                                out_o,
    output logic [Q_M+Q_N:0]                    sum_o
);
    localparam int W  = 1 + Q_M + Q_N;
    localparam int AW = $clog2(N_INPUTS + 1);
    state_t              r_state;
    logic [AW-1:0]       r_k;
    logic [N_INPUTS-1:0] r_x;
    logic [W-1:0]        r_w [0:N_INPUTS];
    logic [W-1:0]        r_sum, w_sum, w_din;
    logic                r_out, w_pos, w_idle, w_wr, w_xk;
    assign w_idle      = (r_state == IDLE);
    assign in_ready_o  = w_idle;
    assign cfg_ready_o = w_idle;
    assign out_valid_o = (r_state == DONE);
    assign out_o       = r_out;
    assign sum_o       = r_sum;
    assign w_wr        = cfg_we_i && w_idle && (cfg_addr_i <= AW'(N_INPUTS));
    assign w_xk        = |(r_x & (N_INPUTS'(1) << r_k));
    assign w_din       = (r_state == BIAS) ? r_w[N_INPUTS] : r_w[r_k];
    neuron_acc #(.W(W), .AW(AW)) u_acc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (w_idle && in_valid_i),
        .add_i ((r_state == ACCUM && w_xk) || r_state == BIAS),
        .din_i (w_din),
        .sum_o (w_sum),
        .pos_o (w_pos)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_x     <= '0;
            r_out   <= 1'b0;
            r_sum   <= '0;
            for (int i = 0; i <= N_INPUTS; i++) r_w[i] <= '0;
        end else begin
            if (w_wr) r_w[cfg_addr_i] <= cfg_data_i;
            case (r_state)
                IDLE: if (in_valid_i) begin
                    r_x     <= x_i;
                    r_k     <= '0;
                    r_state <= ACCUM;
                end
                ACCUM: begin
                    r_k <= r_k + 1'b1;
                    if (r_k == AW'(N_INPUTS - 1)) r_state <= BIAS;
                end
                BIAS: begin
                    r_out   <= w_pos;
                    r_sum   <= w_sum;
                    r_state <= DONE;
                end
                DONE: if (out_ready_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb_neuron_mac_sequencer: directed and randomized checks of the neuron against an integer reference model
module tb_neuron_mac_sequencer;
    localparam int N = 2;
    logic          clk_i = 1'b0;
    logic          rst_i, in_valid_i, in_ready_o, cfg_we_i, cfg_ready_o;
    logic          out_valid_o, out_ready_i, out_o;
    logic [N-1:0]  x_i;
    logic [1:0]    cfg_addr_i;
    logic [31:0]   cfg_data_i, sum_o;
    logic [31:0]   m_w [0:N];
    int            checks = 0, failures = 0;

    neuron_mac_sequencer #(.N_INPUTS(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .x_i(x_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
        .cfg_ready_o(cfg_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_o(out_o), .sum_o(sum_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint sm2i(input logic [31:0] v);
        return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
    endfunction

    task automatic model(input logic [N-1:0] x, output logic [31:0] es, output logic eo);
        longint s, a;
        s = sm2i(m_w[N]);
        for (int i = 0; i < N; i++) if (x[i]) s += sm2i(m_w[i]);
        a = (s < 0) ? -s : s;
        if (a > 64'h7FFF_FFFF) a = 64'h7FFF_FFFF;
        es = {s < 0, a[30:0]};
        eo = s > 0;
    endtask

    function automatic logic [31:0] rand_w();
        logic [31:0] r;
        int m;
        r = $urandom;
        m = $urandom_range(0, 3);
        if (m == 1) r = {r[31], 15'd0, r[15:0]};
        if (m == 2) r = {r[31], 31'h7FFF_FFFF};
        if (m == 3) r = {r[31], 31'd0};
        return r;
    endfunction

    task automatic wr(input logic [1:0] addr, input logic [31:0] d);
        cfg_we_i = 1'b1; cfg_addr_i = addr; cfg_data_i = d;
        @(negedge clk_i);
        cfg_we_i = 1'b0;
        if (addr <= N) m_w[addr] = d;
    endtask

    task automatic issue(input string tag, input logic [N-1:0] x);
        check({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1; x_i = x;
        @(negedge clk_i);
        in_valid_i = 1'b0; x_i = N'($urandom);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 1;
        while (!out_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(N + 2));
    endtask

    task automatic check_res(input string tag, input logic [N-1:0] x);
        logic [31:0] es;
        logic eo;
        model(x, es, eo);
        check({tag, "_sum"}, sum_o, es);
        check({tag, "_out"}, 32'(out_o), 32'(eo));
    endtask

    task automatic drain(input string tag);
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        check({tag, "_ready_after"}, 32'(in_ready_o), 32'd1);
        check({tag, "_valid_after"}, 32'(out_valid_o), 32'd0);
    endtask

    task automatic run(input string tag, input logic [N-1:0] x);
        issue(tag, x);
        wait_valid(tag);
        check_res(tag, x);
        drain(tag);
    endtask

    task automatic load_ref();
        wr(2'd0, 32'h0000_C76F);
        wr(2'd1, 32'h0000_B23F);
        wr(2'd2, 32'h8000_5363);
    endtask

    initial begin
        logic [31:0] es;
        logic eo;
        rst_i = 1'b1; in_valid_i = 1'b0; x_i = '0; cfg_we_i = 1'b0; cfg_addr_i = '0;
        cfg_data_i = '0; out_ready_i = 1'b0;
        for (int i = 0; i <= N; i++) m_w[i] = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_cfg_ready", 32'(cfg_ready_o), 32'd1);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out", 32'(out_o), 32'd0);
        check("rst_sum", sum_o, 32'd0);

        load_ref();
        run("ref_x00", 2'b00);
        check("ref_x00_const", sum_o, 32'h8000_5363);
        run("ref_x10", 2'b10);
        check("ref_x10_const", sum_o, 32'h0000_5EDC);
        run("ref_x01", 2'b01);
        check("ref_x01_const", sum_o, 32'h0000_740C);
        run("ref_x11", 2'b11);
        check("ref_x11_const", sum_o, 32'h0001_264B);
        run("b2b_x11", 2'b11);
        check("b2b_x11_const", sum_o, 32'h0001_264B);

        wr(2'd0, 32'h7FFF_FFFF); wr(2'd1, 32'h7FFF_FFFF); wr(2'd2, 32'h0000_0000);
        run("sat_pos", 2'b11);
        check("sat_pos_const", sum_o, 32'h7FFF_FFFF);
        wr(2'd0, 32'hFFFF_FFFF); wr(2'd1, 32'hFFFF_FFFF); wr(2'd2, 32'hFFFF_FFFF);
        run("sat_neg", 2'b11);
        check("sat_neg_const", sum_o, 32'hFFFF_FFFF);
        wr(2'd0, 32'h8000_C76F); wr(2'd2, 32'h8000_C76F);
        run("neg_sum", 2'b01);
        check("neg_sum_const", sum_o, 32'h8001_8EDE);
        wr(2'd0, 32'h0000_5363); wr(2'd2, 32'h8000_5363);
        run("zero_sum", 2'b01);
        check("zero_sum_const", sum_o, 32'h0000_0000);
        wr(2'd0, 32'h8000_0000); wr(2'd2, 32'h0000_0000);
        run("neg_zero", 2'b01);
        check("neg_zero_const", sum_o, 32'h0000_0000);

        load_ref();
        wr(2'd3, 32'h1234_5678);
        run("bad_addr", 2'b11);

        // write landing on the same edge as the accept must be used by that pattern
        cfg_we_i = 1'b1; cfg_addr_i = 2'd1; cfg_data_i = 32'h0000_1000;
        m_w[1] = 32'h0000_1000;
        issue("same_edge", 2'b10);
        cfg_we_i = 1'b0;
        wait_valid("same_edge");
        check_res("same_edge", 2'b10);
        drain("same_edge");

        load_ref();
        issue("stall", 2'b01);
        wait_valid("stall");
        model(2'b01, es, eo);
        for (int c = 0; c < 5; c++) begin
            cfg_we_i = 1'b1; cfg_addr_i = 2'd0; cfg_data_i = 32'h0000_0000;
            in_valid_i = 1'b1; x_i = 2'b11; out_ready_i = 1'b0;
            @(negedge clk_i);
            check("stall_valid", 32'(out_valid_o), 32'd1);
            check("stall_sum", sum_o, es);
            check("stall_in_ready", 32'(in_ready_o), 32'd0);
            check("stall_cfg_ready", 32'(cfg_ready_o), 32'd0);
        end
        cfg_we_i = 1'b0; in_valid_i = 1'b0;
        drain("stall");
        run("post_stall", 2'b01);
        check("post_stall_const", sum_o, 32'h0000_740C);

        issue("mid_rst", 2'b11);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i <= N; i++) m_w[i] = '0;
        check("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready_o), 32'd1);
        run("after_rst", 2'b11);
        check("after_rst_const", sum_o, 32'h0000_0000);

        for (int t = 0; t < 16; t++) begin
            logic [N-1:0] xr;
            for (int a = 0; a <= N; a++) wr(2'(a), rand_w());
            xr = N'($urandom);
            run("rand", xr);
            if (t % 4 == 0) run("rand_b2b", xr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
